fnd_scan_ctrl: RTL and testbench

Upstream driver for the 4-digit FND path. Accepts a binary value on a load strobe and converts it to four BCD digits with a sequential double-dabble engine. It holds the digits in a display buffer and time-multiplexes them.
- Each scan slot presents a digit-select code, that digit's BCD nibble and a blank flag to the BCD-to-FND decode stage.

---
 rtl/fnd_scan_ctrl_pkg.sv | 34 +++
 rtl/fnd_scan_ctrl_prescaler.sv | 31 +++
 rtl/fnd_scan_ctrl.sv | 100 ++++++++++
 tb/tb_fnd_scan_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fnd_scan_ctrl_pkg.sv
// fnd_scan_ctrl shared definitions: widths, digit indices, FSM states
// and the double-dabble nibble adjust helper.
package fnd_scan_ctrl_pkg;

  localparam int BIN_W = 14;
  localparam int BCD_W = 16;

  localparam logic [1:0] DIG_ONES  = 2'd0;
  localparam logic [1:0] DIG_TENS  = 2'd1;
  localparam logic [1:0] DIG_HUNDS = 2'd2;
  localparam logic [1:0] DIG_THOUS = 2'd3;

  localparam logic [BIN_W-1:0] BCD_MAX = 14'd9999;
  localparam logic [3:0] ITER_LAST = 4'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  function automatic logic [BCD_W-1:0] dabble_adj(
    input logic [BCD_W-1:0] b
  );
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl_prescaler.sv
// Free-running scan-slot prescaler with a 2-bit digit counter.
// The tick is decoded from the count; the digit advances on the next edge.
module fnd_scan_ctrl_prescaler #(
  parameter int P_SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  output logic       tick,
  output logic [1:0] sel
);

  localparam int CW = $clog2(P_SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(P_SCAN_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      sel <= 2'd0;
    end else if (tick) begin
      cnt <= '0;
      sel <= sel + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// 4-digit FND scan driver: sequential binary-to-BCD conversion into a
// display buffer, time-multiplexed digit output with leading-zero blanking.
module fnd_scan_ctrl #(
  parameter int P_SCAN_DIV = 100000,
  parameter bit P_LZB      = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [13:0] i_value,
  input  logic        i_en,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_ovf,
  output logic        o_scan_tick,
  output logic [1:0]  o_digitSelect,
  output logic [3:0]  o_bcd,
  output logic        o_blank
);

  import fnd_scan_ctrl_pkg::*;

  state_t             state;
  logic [BIN_W-1:0]   bin;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   disp;
  logic [3:0]         iter;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]   hi;
  logic               blank;

  fnd_scan_ctrl_prescaler #(
    .P_SCAN_DIV(P_SCAN_DIV)
  ) u_prescaler (
    .clk  (i_clk),
    .reset(i_reset),
    .tick (o_scan_tick),
    .sel  (o_digitSelect)
  );

  assign adj     = dabble_adj(bcd);
  assign shifted = {adj, bin} << 1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= S_IDLE;
      bin    <= '0;
      bcd    <= '0;
      iter   <= '0;
      disp   <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_ovf  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_load) begin
            bin    <= (i_value > BCD_MAX) ? BCD_MAX : i_value;
            o_ovf  <= (i_value > BCD_MAX);
            bcd    <= '0;
            iter   <= '0;
            o_busy <= 1'b1;
            state  <= S_CONV;
          end
        end
        S_CONV: begin
          {bcd, bin} <= shifted;
          iter       <= iter + 4'd1;
          // Buffer takes the final accumulator directly, never a partial one
          if (iter == ITER_LAST) begin
            disp   <= shifted[BCD_W+BIN_W-1:BIN_W];
            o_done <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_bcd = disp[{o_digitSelect, 2'b00} +: 4];
  assign hi    = disp >> {o_digitSelect, 2'b00};

  always_comb begin
    blank = 1'b0;
    if (!i_en)
      blank = 1'b1;
    else if (P_LZB && o_digitSelect != DIG_ONES)
      blank = (hi == '0);
  end

  assign o_blank = blank;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: decimal reference model,
// directed plan cases followed by randomized loads and enables.
module tb_fnd_scan_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_load = 1'b0;
  logic [13:0] i_value = '0;
  logic        i_en = 1'b1;
  logic        o_busy, o_done, o_ovf, o_scan_tick, o_blank;
  logic [1:0]  o_digitSelect;
  logic [3:0]  o_bcd;

  fnd_scan_ctrl #(
    .P_SCAN_DIV(DIV),
    .P_LZB(1'b1)
  ) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_load(i_load),
    .i_value(i_value),
    .i_en(i_en),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_ovf(o_ovf),
    .o_scan_tick(o_scan_tick),
    .o_digitSelect(o_digitSelect),
    .o_bcd(o_bcd),
    .o_blank(o_blank)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t q[$];
  int   k;
  int   total = 0;
  int   bad = 0;
  int   model_buf = 0;
  int   model_ovf = 0;

  // cycles since reset release; drives the expected scan position
  always @(posedge clk)
    if (i_reset) k <= 0;
    else k <= k + 1;

  function automatic int pow10(input int d);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (k=%0d t=%0t)",
               name, got, exp, k, $time);
    end
  endtask

  always @(negedge clk) begin
    int   sel;
    exp_t e;
    if (!i_reset) begin
      sel = (k / DIV) % 4;
      chk("scan_tick", int'(o_scan_tick), int'(k % DIV == DIV - 1));
      chk("digit_sel", int'(o_digitSelect), sel);
      chk("busy", int'(o_busy), int'(q.size() != 0));
      chk("ovf", int'(o_ovf), model_ovf);
      if (o_done) begin
        if (q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done_time", k, e.due);
          model_buf = e.val;
        end
      end else if (q.size() != 0 && k >= q[0].due) begin
        chk("done_missing", 0, 1);
        void'(q.pop_front());
      end
      chk("bcd", int'(o_bcd), (model_buf / pow10(sel)) % 10);
      chk("blank", int'(o_blank),
          int'(!i_en || (sel != 0 && model_buf / pow10(sel) == 0)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int v);
    bit   acc;
    exp_t e;
    acc     = (q.size() == 0);
    i_load  = 1'b1;
    i_value = v[13:0];
    step();
    if (acc) begin
      e.val = (v > 9999) ? 9999 : v;
      e.due = k + 14;
      q.push_back(e);
      model_ovf = int'(v > 9999);
    end
    i_load = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    if (q.size() != 0) chk("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    q.delete();
    model_buf = 0;
    model_ovf = 0;
    repeat (2) step();
    i_reset = 1'b0;
  endtask

  task automatic load_show(input int v);
    load(v);
    wait_idle();
    repeat (17) step();
  endtask

  initial begin
    int v;
    do_reset();
    repeat (20) step();

    load_show(1234);
    load_show(7);
    load_show(0);
    load_show(12000);
    load_show(5);

    load(1234);
    repeat (4) step();
    load(5678);
    wait_idle();
    repeat (17) step();

    load(4321);
    repeat (7) step();
    do_reset();
    repeat (20) step();

    load_show(4321);
    i_en = 1'b0;
    repeat (17) step();
    i_en = 1'b1;
    repeat (17) step();

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom_range(0, 9);
        1: v = $urandom_range(0, 9999);
        2: v = $urandom_range(10000, 16383);
        default: v = $urandom_range(0, 999);
      endcase
      load(v);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 12)) step();
        load($urandom_range(0, 16383));
      end
      wait_idle();
      i_en = ($urandom_range(0, 4) != 0);
      repeat ($urandom_range(0, 20)) step();
    end

    i_en = 1'b1;
    repeat (4) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
